mem_cs_wait: RTL



---
 rtl/hc21_bus_pkg.sv | 23 ++
 rtl/mem_region_dec.sv | 29 ++
 rtl/mem_cs_wait.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hc21_bus_pkg.sv
// Shared bus-decode types for the hc21 memory and I/O chip-select logic.
package hc21_bus_pkg;

    localparam int WS_W_DEF = 3;

    typedef enum logic [1:0] {
        REG_ROM = 2'd0,
        REG_RAM = 2'd1,
        REG_EXT = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

endpackage

// File: rtl/mem_region_dec.sv
// Combinational page-to-region decode with per-region wait-state count.
module mem_region_dec
    import hc21_bus_pkg::*;
#(
    parameter logic [6:0] ROM_PAGES = 7'd4,
    parameter logic [6:0] RAM_END   = 7'd68,
    parameter int         ROM_WS    = 2,
    parameter int         RAM_WS    = 0,
    parameter int         EXT_WS    = 3,
    parameter int         WS_W      = WS_W_DEF
) (
    input  logic [6:0]      i_paddr,
    output region_t         o_region,
    output logic [WS_W-1:0] o_ws_count
);

    always_comb begin
        o_region   = REG_EXT;
        o_ws_count = WS_W'(EXT_WS);
        if (i_paddr < ROM_PAGES) begin
            o_region   = REG_ROM;
            o_ws_count = WS_W'(ROM_WS);
        end else if (i_paddr < RAM_END) begin
            o_region   = REG_RAM;
            o_ws_count = WS_W'(RAM_WS);
        end
    end

endmodule

// File: rtl/mem_cs_wait.sv
// Z80 memory chip-select / wait-state generator behind the MMU.
// Optional ROM write protection: define MEM_CS_WAIT_ROM_WP_EN.
//
// state   | meaning
// IDLE    | no cycle owned, waiting for a memory read/write start
// WAIT    | strobes asserted, wait_n low while counter runs down
// HOLD    | strobes asserted until mreq_n rises
module mem_cs_wait
    import hc21_bus_pkg::*;
#(
    parameter logic [6:0] ROM_PAGES = 7'd4,
    parameter logic [6:0] RAM_END   = 7'd68,
    parameter int         ROM_WS    = 2,
    parameter int         RAM_WS    = 0,
    parameter int         EXT_WS    = 3,
    parameter int         WS_W      = WS_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mreq_n,
    input  logic       rfsh_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [6:0] paddr,
    output logic       rom_cs_n,
    output logic       ram_cs_n,
    output logic       ext_cs_n,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic       wait_n,
    output logic       busy
`ifdef MEM_CS_WAIT_ROM_WP_EN
    ,
    output logic       wp_fault
`endif
);

    region_t         w_region;
    logic [WS_W-1:0] w_ws;
    dir_t            w_dir;
    logic            w_start;
    region_t         w_sel_region;
    dir_t            w_sel_dir;
    logic            w_rom_en;
    logic            w_ram_en;
    logic            w_ext_en;
    logic            w_oe_en;
    logic            w_we_en;

    state_t          r_state;
    region_t         r_region;
    dir_t            r_dir;
    logic [WS_W-1:0] r_count;
    logic            r_rom_cs_n;
    logic            r_ram_cs_n;
    logic            r_ext_cs_n;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_wait_n;

    mem_region_dec #(
        .ROM_PAGES (ROM_PAGES),
        .RAM_END   (RAM_END),
        .ROM_WS    (ROM_WS),
        .RAM_WS    (RAM_WS),
        .EXT_WS    (EXT_WS),
        .WS_W      (WS_W)
    ) u_dec (
        .i_paddr    (paddr),
        .o_region   (w_region),
        .o_ws_count (w_ws)
    );

    // Refresh cycles also pull mreq_n low; rfsh_n keeps them out.
    assign w_start = !mreq_n && rfsh_n && (!rd_n || !wr_n);
    assign w_dir   = wr_n ? DIR_RD : DIR_WR;

`ifdef MEM_CS_WAIT_ROM_WP_EN
    logic w_wp_hit;
    logic r_wp_fault;
`endif

    // Strobe enables come from the live decode at start, then from the latched cycle.
    always_comb begin
        w_sel_region = (r_state == ST_IDLE) ? w_region : r_region;
        w_sel_dir    = (r_state == ST_IDLE) ? w_dir : r_dir;
        w_rom_en     = (w_sel_region == REG_ROM);
        w_ram_en     = (w_sel_region == REG_RAM);
        w_ext_en     = (w_sel_region == REG_EXT);
        w_oe_en      = (w_sel_dir == DIR_RD);
        w_we_en      = (w_sel_dir == DIR_WR);
`ifdef MEM_CS_WAIT_ROM_WP_EN
        w_wp_hit = w_rom_en && w_we_en;
        if (w_wp_hit) begin
            w_rom_en = 1'b0;
            w_we_en  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_region   <= REG_ROM;
            r_dir      <= DIR_RD;
            r_count    <= '0;
            r_rom_cs_n <= 1'b1;
            r_ram_cs_n <= 1'b1;
            r_ext_cs_n <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_wait_n   <= 1'b1;
`ifdef MEM_CS_WAIT_ROM_WP_EN
            r_wp_fault <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_region   <= w_region;
                        r_dir      <= w_dir;
                        r_count    <= w_ws;
                        r_rom_cs_n <= !w_rom_en;
                        r_ram_cs_n <= !w_ram_en;
                        r_ext_cs_n <= !w_ext_en;
                        r_oe_n     <= !w_oe_en;
                        r_we_n     <= !w_we_en;
`ifdef MEM_CS_WAIT_ROM_WP_EN
                        if (w_wp_hit) r_wp_fault <= 1'b1;
`endif
                        if (w_ws != '0) begin
                            r_state  <= ST_WAIT;
                            r_wait_n <= 1'b0;
                        end else begin
                            r_state  <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mreq_n) begin
                        r_state    <= ST_IDLE;
                        r_count    <= '0;
                        r_wait_n   <= 1'b1;
                        r_rom_cs_n <= 1'b1;
                        r_ram_cs_n <= 1'b1;
                        r_ext_cs_n <= 1'b1;
                        r_oe_n     <= 1'b1;
                        r_we_n     <= 1'b1;
                    end else if (r_count == WS_W'(1)) begin
                        r_state  <= ST_HOLD;
                        r_count  <= '0;
                        r_wait_n <= 1'b1;
                    end else begin
                        r_count <= r_count - WS_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (mreq_n) begin
                        r_state    <= ST_IDLE;
                        r_rom_cs_n <= 1'b1;
                        r_ram_cs_n <= 1'b1;
                        r_ext_cs_n <= 1'b1;
                        r_oe_n     <= 1'b1;
                        r_we_n     <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rom_cs_n = r_rom_cs_n;
    assign ram_cs_n = r_ram_cs_n;
    assign ext_cs_n = r_ext_cs_n;
    assign mem_oe_n = r_oe_n;
    assign mem_we_n = r_we_n;
    assign wait_n   = r_wait_n;
    assign busy     = (r_state != ST_IDLE);
`ifdef MEM_CS_WAIT_ROM_WP_EN
    assign wp_fault = r_wp_fault;
`endif

endmodule
